// File: rtl/user_bitcount_accel.sv
// user_bitcount_accel: OBI subordinate with NumAcc popcount accumulators.
// An ADD write counts the ones of wdata BitsPerCycle bits per cycle while the
// port is held off (gnt low), then adds the count to the selected channel.
// Register map per channel (ch = addr[4 +: clog2(NumAcc)], reg = addr[3:2]):
//   0x0 CLEAR (W), 0x4 ADD (W), 0x8 VALUE (R), 0xC STATUS (R, bit0 = flag).
// Optional feature macro: USER_BITCOUNT_SAT_EN
//   defined   -> ADD saturates at 2^AccWidth-1 and sets the sticky channel flag
//   undefined -> ADD wraps modulo 2^AccWidth, no flag registers, STATUS reads 0

package obi_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [0:0]  aid;
  } obi_default_a_chan_t;

  typedef struct packed {
    logic                req;
    obi_default_a_chan_t a;
  } obi_default_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
    logic        r_optional;
  } obi_default_r_chan_t;

  typedef struct packed {
    logic                gnt;
    logic                rvalid;
    obi_default_r_chan_t r;
  } obi_default_rsp_t;

endpackage

module user_bitcount_accel #(
  parameter obi_pkg::obi_cfg_t ObiCfg       = obi_pkg::ObiDefaultConfig,
  parameter type               obi_req_t    = obi_pkg::obi_default_req_t,
  parameter type               obi_rsp_t    = obi_pkg::obi_default_rsp_t,
  parameter int unsigned       NumAcc       = 4,
  parameter int unsigned       AccWidth     = 16,
  parameter int unsigned       BitsPerCycle = 8
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  obi_req_t obi_req_i,
  output obi_rsp_t obi_rsp_o
);

  localparam int unsigned DataWidth = ObiCfg.DataWidth;
  localparam int unsigned IdWidth   = ObiCfg.IdWidth;
  localparam int unsigned NumChunks = DataWidth / BitsPerCycle;
  localparam int unsigned ChW       = (NumAcc > 1) ? $clog2(NumAcc) : 1;
  localparam int unsigned CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam int unsigned SumW      = $clog2(DataWidth + 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  // Ones count of one chunk, sized to hold a full-word count.
  function automatic logic [SumW-1:0] popcount_chunk(input logic [BitsPerCycle-1:0] bits);
    logic [SumW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(BitsPerCycle); i++) begin
      cnt = cnt + SumW'(bits[i]);
    end
    return cnt;
  endfunction

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  state_e                 state_q;
  logic [1:0]             reg_sel;
  logic [ChW-1:0]         ch_sel;
  logic                   ch_valid;
  logic                   accept;
  logic                   is_add;
  logic                   is_clear;
  logic                   is_err;
  logic [DataWidth-1:0]   rd_data;

  logic [AccWidth-1:0]    acc_q [NumAcc];
`ifdef USER_BITCOUNT_SAT_EN
  logic                   flag_q [NumAcc];
`endif

  // High address bits are don't-care; fold the request into a sink.
  logic unused_req;
  assign unused_req = ^obi_req_i;

  assign reg_sel = obi_req_i.a.addr[3:2];

  if (NumAcc > 1) begin : g_ch_multi
    assign ch_sel = obi_req_i.a.addr[4 +: ChW];
  end else begin : g_ch_single
    assign ch_sel = '0;
  end

  // Widened compare so spare channel codes are caught for any NumAcc.
  assign ch_valid = ({1'b0, ch_sel} < (ChW + 1)'(NumAcc));

  assign accept   = obi_req_i.req && (state_q == IDLE);
  assign is_add   = obi_req_i.a.we && (reg_sel == 2'd1) && ch_valid;
  assign is_clear = obi_req_i.a.we && (reg_sel == 2'd0) && ch_valid;
  // Writes are legal only to CLEAR/ADD, reads only from VALUE/STATUS.
  assign is_err   = !ch_valid || (obi_req_i.a.we ? reg_sel[1] : !reg_sel[1]);

  // Read data for a VALUE/STATUS access, zero for everything else.
  always_comb begin
    // NOTE: default first so every path assigns rd_data and no latch is inferred.
    rd_data = '0;
    if (!obi_req_i.a.we && ch_valid) begin
      if (reg_sel == 2'd2) begin
        rd_data = DataWidth'(acc_q[ch_sel]);
      end
`ifdef USER_BITCOUNT_SAT_EN
      else if (reg_sel == 2'd3) begin
        rd_data = DataWidth'(flag_q[ch_sel]);
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Multi-cycle popcount datapath
  // ---------------------------------------------------------------------------
  logic [DataWidth-1:0]                     wdata_q;
  logic [NumChunks-1:0][BitsPerCycle-1:0]   chunks;
  logic [ChW-1:0]                           ch_q;
  logic [CntW-1:0]                          k_q;
  logic [SumW-1:0]                          psum_q;
  logic [SumW-1:0]                          chunk_cnt;
  logic [SumW-1:0]                          sum_total;
  logic                                     last_chunk;
  logic                                     pre_last;
  logic [AccWidth-1:0]                      acc_next;
  logic                                     rvalid_q;
  logic                                     err_q;
  logic [DataWidth-1:0]                     rdata_q;
  logic [IdWidth-1:0]                       rid_q;

  assign chunks     = wdata_q;
  assign chunk_cnt  = popcount_chunk(chunks[k_q]);
  assign sum_total  = psum_q + chunk_cnt;
  assign last_chunk = (k_q == CntW'(NumChunks - 1));
  // rvalid is registered, so it is raised one edge ahead of the last chunk.
  assign pre_last   = (NumChunks > 1) && (k_q == CntW'(NumChunks - 2));

`ifdef USER_BITCOUNT_SAT_EN
  localparam int unsigned AccSumW = ((AccWidth > SumW) ? AccWidth : SumW) + 1;

  logic [AccSumW-1:0] acc_sum;
  logic               acc_ovf;

  assign acc_sum  = AccSumW'(acc_q[ch_q]) + AccSumW'(sum_total);
  assign acc_ovf  = |acc_sum[AccSumW-1:AccWidth];
  assign acc_next = acc_ovf ? '1 : acc_sum[AccWidth-1:0];
`else
  assign acc_next = acc_q[ch_q] + AccWidth'(sum_total);
`endif

  // Control FSM: grant/accept, chunk sequencing and the registered response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      wdata_q  <= '0;
      ch_q     <= '0;
      k_q      <= '0;
      psum_q   <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      rvalid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            rid_q <= obi_req_i.a.aid;
            if (is_add) begin
              state_q  <= BUSY;
              wdata_q  <= obi_req_i.a.wdata;
              ch_q     <= ch_sel;
              k_q      <= '0;
              psum_q   <= '0;
              rvalid_q <= (NumChunks == 1);
              err_q    <= 1'b0;
              rdata_q  <= '0;
            end else begin
              rvalid_q <= 1'b1;
              err_q    <= is_err;
              rdata_q  <= rd_data;
            end
          end
        end
        BUSY: begin
          rvalid_q <= pre_last;
          if (last_chunk) begin
            state_q <= IDLE;
            k_q     <= '0;
            psum_q  <= '0;
          end else begin
            k_q    <= k_q + 1'b1;
            psum_q <= sum_total;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Accumulator file: CLEAR on accept, ADD result on the final busy edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: reset clears every channel, so this array stays flops with reset, not a RAM.
      for (int i = 0; i < int'(NumAcc); i++) begin
        acc_q[i] <= '0;
      end
    end else if (accept && is_clear) begin
      acc_q[ch_sel] <= '0;
    end else if ((state_q == BUSY) && last_chunk) begin
      acc_q[ch_q] <= acc_next;
    end
  end

`ifdef USER_BITCOUNT_SAT_EN
  // Sticky overflow flags: set by a saturating ADD, cleared only by CLEAR.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumAcc); i++) begin
        flag_q[i] <= 1'b0;
      end
    end else if (accept && is_clear) begin
      flag_q[ch_sel] <= 1'b0;
    end else if ((state_q == BUSY) && last_chunk && acc_ovf) begin
      flag_q[ch_q] <= 1'b1;
    end
  end
`endif

  // Response port: combinational grant, registered response channel.
  always_comb begin
    obi_rsp_o              = '0;
    obi_rsp_o.gnt          = accept;
    obi_rsp_o.rvalid       = rvalid_q;
    obi_rsp_o.r.rdata      = rdata_q;
    obi_rsp_o.r.rid        = rid_q;
    obi_rsp_o.r.err        = err_q;
    obi_rsp_o.r.r_optional = 1'b0;
  end

endmodule

// File: tb/tb_user_bitcount_accel.sv
// Self-checking bench for user_bitcount_accel. Two instances share clock and
// reset: a default one (AccWidth=16) and a narrow one (AccWidth=6) to reach the
// wrap/saturation boundary. A behavioural model tracks every channel.

module tb_user_bitcount_accel;

  localparam obi_pkg::obi_cfg_t Cfg = '{AddrWidth: 32, DataWidth: 32, IdWidth: 4};
  localparam int NumChunks = 4;

`ifdef USER_BITCOUNT_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } a_chan_t;

  typedef struct packed {
    logic    req;
    a_chan_t a;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
    logic        r_optional;
  } r_chan_t;

  typedef struct packed {
    logic    gnt;
    logic    rvalid;
    r_chan_t r;
  } rsp_t;

  logic clk;
  logic rst_n;
  req_t req [2];
  rsp_t rsp [2];

  int    n_checks;
  int    n_errors;
  string phase;

  // Reference state: plain integers per instance and channel.
  longint unsigned model_acc  [2][4];
  bit              model_flag [2][4];
  int              acc_w      [2] = '{16, 6};

  user_bitcount_accel #(
    .ObiCfg      (Cfg),
    .obi_req_t   (req_t),
    .obi_rsp_t   (rsp_t),
    .NumAcc      (4),
    .AccWidth    (16),
    .BitsPerCycle(8)
  ) u_dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .obi_req_i(req[0]),
    .obi_rsp_o(rsp[0])
  );

  user_bitcount_accel #(
    .ObiCfg      (Cfg),
    .obi_req_t   (req_t),
    .obi_rsp_t   (rsp_t),
    .NumAcc      (4),
    .AccWidth    (6),
    .BitsPerCycle(8)
  ) u_dut_narrow (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .obi_req_i(req[1]),
    .obi_rsp_o(rsp[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL [%s] %s: got 0x%0h expected 0x%0h", phase, tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 4; c++) begin
        model_acc[s][c]  = 0;
        model_flag[s][c] = 1'b0;
      end
    end
  endtask

  // One OBI transaction; starts and ends just after a falling edge.
  task automatic txn(input int s, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] aid,
                     output logic [31:0] rdata);
    int              reg_i;
    int              ch;
    int              exp_lat;
    int              c;
    bit              exp_err;
    bit              got;
    logic [31:0]     exp_rdata;
    longint unsigned sum;
    longint unsigned maxv;

    reg_i     = int'(addr[3:2]);
    ch        = int'(addr[5:4]);
    exp_err   = we ? (reg_i >= 2) : (reg_i < 2);
    exp_rdata = '0;
    if (!exp_err && !we) begin
      exp_rdata = (reg_i == 2) ? 32'(model_acc[s][ch]) : 32'(model_flag[s][ch]);
    end
    exp_lat = (we && reg_i == 1) ? NumChunks : 1;

    req[s] = '{req: 1'b1, a: '{addr: addr, we: we, wdata: wdata, aid: aid}};
    #1;
    check("gnt_idle", 32'(rsp[s].gnt), 32'd1);

    got   = 1'b0;
    c     = 0;
    rdata = '0;
    while (!got && c < 12) begin
      @(negedge clk);
      c++;
      if (exp_lat > 1) check("gnt_busy", 32'(rsp[s].gnt), 32'd0);
      if (rsp[s].rvalid) begin
        got   = 1'b1;
        rdata = rsp[s].r.rdata;
        check("latency", 32'(c), 32'(exp_lat));
        check("rdata", rsp[s].r.rdata, exp_rdata);
        check("err", 32'(rsp[s].r.err), 32'(exp_err));
        check("rid", 32'(rsp[s].r.rid), 32'(aid));
        check("r_optional", 32'(rsp[s].r.r_optional), 32'd0);
      end
      if (got || exp_lat == 1) req[s].req = 1'b0;
    end
    req[s].req = 1'b0;
    if (!got) check("rvalid_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("rvalid_single", 32'(rsp[s].rvalid), 32'd0);

    if (!exp_err && we) begin
      if (reg_i == 0) begin
        model_acc[s][ch]  = 0;
        model_flag[s][ch] = 1'b0;
      end else begin
        maxv = (64'd1 << acc_w[s]) - 1;
        sum  = model_acc[s][ch] + longint'($countones(wdata));
        if (sum > maxv) begin
          if (SatEn) begin
            model_acc[s][ch]  = maxv;
            model_flag[s][ch] = 1'b1;
          end else begin
            model_acc[s][ch] = sum % (maxv + 1);
          end
        end else begin
          model_acc[s][ch] = sum;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] addr;
    logic [31:0] wd;
    int          s;
    int          r;
    int          ch;
    bit          we;

    n_checks = 0;
    n_errors = 0;
    phase    = "reset";
    rst_n    = 1'b0;
    req[0]   = '0;
    req[1]   = '0;
    model_reset();

    // Outputs during reset: idle response, gnt follows req.
    repeat (2) @(negedge clk);
    req[0].req = 1'b1;
    #1;
    check("rst_gnt_follows_req", 32'(rsp[0].gnt), 32'd1);
    check("rst_rvalid", 32'(rsp[0].rvalid), 32'd0);
    check("rst_rdata", rsp[0].r.rdata, 32'd0);
    check("rst_rid", 32'(rsp[0].r.rid), 32'd0);
    check("rst_err", 32'(rsp[0].r.err), 32'd0);
    req[0].req = 1'b0;
    #1;
    check("rst_gnt_no_req", 32'(rsp[0].gnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    phase = "tp_value_after_reset";
    txn(0, 1'b0, 32'h08, 32'h0, 4'h3, rd);
    check("value_ch0_lit", rd, 32'h0);

    phase = "tp_add_ch1";
    txn(0, 1'b1, 32'h14, 32'hF0F0_00FF, 4'h5, rd);
    txn(0, 1'b0, 32'h18, 32'h0, 4'h6, rd);
    check("value_ch1_lit", rd, 32'h10);
    txn(0, 1'b0, 32'h08, 32'h0, 4'h7, rd);
    check("isolation_ch0_lit", rd, 32'h0);

    phase = "tp_clear_ch2";
    txn(0, 1'b1, 32'h24, 32'hFFFF_FFFF, 4'h1, rd);
    txn(0, 1'b1, 32'h24, 32'hFFFF_FFFF, 4'h2, rd);
    txn(0, 1'b0, 32'h28, 32'h0, 4'h3, rd);
    check("value_ch2_lit", rd, 32'h40);
    txn(0, 1'b1, 32'h20, 32'h0, 4'h4, rd);
    txn(0, 1'b0, 32'h28, 32'h0, 4'h5, rd);
    check("value_ch2_cleared_lit", rd, 32'h0);

    phase = "tp_errors";
    txn(0, 1'b0, 32'h04, 32'h0, 4'hA, rd);
    check("err_read_add_rdata_lit", rd, 32'h0);
    txn(0, 1'b1, 32'h08, 32'h1234, 4'hB, rd);
    txn(0, 1'b0, 32'h18, 32'h0, 4'hC, rd);
    check("value_ch1_unchanged_lit", rd, 32'h10);

    phase = "tp_narrow_wrap_sat";
    txn(1, 1'b1, 32'h04, 32'hFFFF_FFFF, 4'h1, rd);
    txn(1, 1'b1, 32'h04, 32'hFFFF_FFFF, 4'h2, rd);
    txn(1, 1'b0, 32'h08, 32'h0, 4'h3, rd);
    check("narrow_value_lit", rd, SatEn ? 32'h3F : 32'h0);
    txn(1, 1'b0, 32'h0C, 32'h0, 4'h4, rd);
    check("narrow_status_lit", rd, SatEn ? 32'h1 : 32'h0);
    txn(1, 1'b1, 32'h00, 32'h0, 4'h5, rd);
    txn(1, 1'b0, 32'h0C, 32'h0, 4'h6, rd);
    check("narrow_status_cleared_lit", rd, 32'h0);

    phase = "tp_reset_mid_add";
    req[0] = '{req: 1'b1, a: '{addr: 32'h34, we: 1'b1, wdata: 32'hDEAD_BEEF, aid: 4'h7}};
    #1;
    check("gnt_idle", 32'(rsp[0].gnt), 32'd1);
    @(negedge clk);
    req[0].req = 1'b0;
    check("gnt_busy", 32'(rsp[0].gnt), 32'd0);
    check("rvalid_early", 32'(rsp[0].rvalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(rsp[0].rvalid), 32'd0);
    check("mid_rst_rid", 32'(rsp[0].r.rid), 32'd0);
    check("mid_rst_err", 32'(rsp[0].r.err), 32'd0);
    check("mid_rst_rdata", rsp[0].r.rdata, 32'd0);
    req[0].req = 1'b1;
    req[0].a.we = 1'b0;
    #1;
    check("mid_rst_gnt_follows_req", 32'(rsp[0].gnt), 32'd1);
    req[0].req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("dropped_add_no_rvalid", 32'(rsp[0].rvalid), 32'd0);
    end
    rst_n = 1'b1;
    model_reset();
    txn(0, 1'b0, 32'h38, 32'h0, 4'h9, rd);
    check("value_ch3_after_reset_lit", rd, 32'h0);
    txn(0, 1'b0, 32'h18, 32'h0, 4'hE, rd);
    check("value_ch1_after_reset_lit", rd, 32'h0);

    phase = "random";
    for (int i = 0; i < 160; i++) begin
      s  = $urandom_range(0, 1);
      r  = $urandom_range(0, 3);
      ch = $urandom_range(0, 3);
      we = (r < 2) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       wd = 32'hFFFF_FFFF;
        1:       wd = 32'h0;
        default: wd = $urandom;
      endcase
      addr = ($urandom & 32'hFFFF_FFC0) | 32'(ch << 4) | 32'(r << 2);
      txn(s, we, addr, wd, 4'($urandom_range(0, 15)), rd);
    end

    // Final sweep of every channel's VALUE and STATUS on both instances.
    phase = "final_sweep";
    for (int si = 0; si < 2; si++) begin
      for (int c = 0; c < 4; c++) begin
        txn(si, 1'b0, 32'(c << 4) | 32'h8, 32'h0, 4'(c), rd);
        txn(si, 1'b0, 32'(c << 4) | 32'hC, 32'h0, 4'(c + 4), rd);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
